// File: rtl/mul_add_seq.sv
// Sequential shift-and-add unit computing quo*opb+rem over 24 iterations,
// used to rebuild a dividend from divider results.
module mul_add_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [49:0] quo,
  input  logic [23:0] opb,
  input  logic [49:0] rem,
  output logic        busy,
  output logic        done,
  output logic [49:0] prod,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [73:0] acc_q, acc_d;
  logic [73:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [49:0] prod_q, prod_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so operations can run back-to-back.
        if (start) begin
          state_d  = BUSY;
          acc_d    = {24'd0, rem};
          mcand_d  = {24'd0, quo};
          mplier_d = opb;
          cnt_d    = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[72:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
        // Result is published from the accumulator value including the last add.
        if (cnt_q == 5'd23) begin
          state_d = DONE;
          prod_d  = acc_d[49:0];
          ovf_d   = |acc_d[73:50];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign prod = prod_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed vector table, corner-case
// sequences and random operations against a plain-arithmetic reference.
module tb_mul_add_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [49:0] quo;
  logic [23:0] opb;
  logic [49:0] rem;
  logic        busy;
  logic        done;
  logic [49:0] prod;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mul_add_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .quo   (quo),
    .opb   (opb),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [49:0] q;
    logic [23:0] b;
    logic [49:0] r;
    logic [49:0] exp_prod;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference: exact integer product plus addend in a wide enough word.
  task automatic model(input logic [49:0] q, input logic [23:0] b, input logic [49:0] r,
                       output logic [49:0] p, output logic o);
    logic [79:0] full;
    full = 80'(q) * 80'(b) + 80'(r);
    p = full[49:0];
    o = (full[79:50] != 0);
  endtask

  function automatic logic [49:0] rnd50();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[49:0];
  endfunction

  // Called at a negedge; start is seen by the next rising edge.
  task automatic issue(input logic [49:0] q, input logic [23:0] b, input logic [49:0] r);
    start = 1'b1;
    quo = q;
    opb = b;
    rem = r;
    @(negedge clk);
    start = 1'b0;
    quo = rnd50();
    opb = 24'($urandom());
    rem = rnd50();
  endtask

  // Entered at the negedge of busy cycle 1; leaves at the negedge of the done cycle.
  // inject_at > 0 pulses a competing start in that busy cycle.
  task automatic wait_result(input string name, input logic [49:0] ep, input logic eo,
                             input int inject_at);
    int busy_cycles;
    bit early_done;
    busy_cycles = 0;
    early_done = 0;
    for (int c = 1; c <= 24; c++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done !== 1'b0) early_done = 1;
      if (c == inject_at) begin
        start = 1'b1;
        quo = 50'd7;
        opb = 24'd7;
        rem = 50'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " busy_len"}, 64'(busy_cycles), 64'd24);
    chk({name, " no_early_done"}, 64'(early_done), 64'd0);
    chk({name, " done"}, 64'({busy, done}), 64'b01);
    chk({name, " prod"}, 64'(prod), 64'(ep));
    chk({name, " ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    logic [49:0] ep, ep2;
    logic        eo, eo2;
    int          seen_done;

    vecs[0] = '{50'd3, 24'd5, 50'd2, 50'd17, 1'b0};
    vecs[1] = '{50'h3FFFFFFFFFFFF, 24'hFFFFFF, 50'h3FFFFFFFFFFFF, 50'h3FFFFFF000000, 1'b1};
    vecs[2] = '{50'd1234, 24'd0, 50'd99, 50'd99, 1'b0};
    vecs[3] = '{50'd0, 24'hFFFFFF, 50'd0, 50'd0, 1'b0};
    vecs[4] = '{50'h2000000000000, 24'd2, 50'd0, 50'd0, 1'b1};
    vecs[5] = '{50'd0, 24'd0, 50'h3FFFFFFFFFFFF, 50'h3FFFFFFFFFFFF, 1'b0};
    vecs[6] = '{50'h3FFFFFFFFFFFF, 24'd1, 50'd1, 50'd0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    quo = '0;
    opb = '0;
    rem = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset prod", 64'(prod), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      issue(vecs[i].q, vecs[i].b, vecs[i].r);
      wait_result($sformatf("vec%0d", i), vecs[i].exp_prod, vecs[i].exp_ovf, 0);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), 64'({busy, done}), 64'b00);
    end

    // Start during busy is ignored
    issue(50'd3, 24'd5, 50'd2);
    wait_result("ignore_start", 50'd17, 1'b0, 10);
    @(negedge clk);
    chk("ignore_start no_second_op", 64'({busy, done}), 64'b00);

    // Back-to-back start in the done cycle
    issue(50'd3, 24'd5, 50'd2);
    wait_result("b2b_first", 50'd17, 1'b0, 0);
    issue(50'd10, 24'd10, 50'd1);
    wait_result("b2b_second", 50'd101, 1'b0, 0);
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse
    issue(50'd3, 24'd5, 50'd2);
    repeat (11) @(negedge clk);
    chk("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort state", 64'({busy, done}), 64'b00);
    chk("abort prod", 64'(prod), 64'd0);
    chk("abort ovf", 64'(ovf), 64'd0);
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    chk("abort no_done", 64'(seen_done), 64'd0);
    issue(50'd10, 24'd10, 50'd1);
    wait_result("after_abort", 50'd101, 1'b0, 0);
    @(negedge clk);

    // Reset beats a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("reset_vs_start", 64'({busy, done}), 64'b00);
    @(negedge clk);
    chk("reset_vs_start later", 64'({busy, done}), 64'b00);

    // Random operations, alternating idle gaps and back-to-back chaining
    for (int n = 0; n < 16; n++) begin
      logic [49:0] q, r;
      logic [23:0] b;
      q = rnd50();
      b = 24'($urandom());
      r = rnd50();
      if (n % 5 == 1) b = 24'hFFFFFF;
      if (n % 5 == 3) q = 50'h3FFFFFFFFFFFF;
      model(q, b, r, ep, eo);
      issue(q, b, r);
      wait_result($sformatf("rand%0d", n), ep, eo, 0);
      if (n % 2 == 0) begin
        q = rnd50();
        b = 24'($urandom_range(0, 4095));
        r = rnd50();
        model(q, b, r, ep2, eo2);
        issue(q, b, r);
        wait_result($sformatf("rand%0d_b2b", n), ep2, eo2, 0);
      end
      @(negedge clk);
      chk($sformatf("rand%0d hold_prod", n), 64'(prod), (n % 2 == 0) ? 64'(ep2) : 64'(ep));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_add_seq.md
MUL_ADD_SEQ -- requirements
Module: mul_add_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to begin an operation; sampled on each rising edge.
REQ-005 quo  in  50  unsigned multiplicand (divider quotient).
REQ-006 opb  in  24  unsigned multiplier (divider divisor).
REQ-007 rem  in  50  unsigned addend (divider remainder).
REQ-008 busy  out  1  operation in progress.
REQ-009 done  out  1  one-cycle pulse; result valid.
REQ-010 prod  out  50  low 50 bits of quo*opb+rem.
REQ-011 ovf  out  1  high when quo*opb+rem does not fit in 50 bits.

Function
REQ-012 The block SHALL compute quo*opb+rem, inverting the divider relation opa = quo*opb + rem.
REQ-013 The block SHALL use three states: IDLE, BUSY and DONE.
REQ-014 A start SHALL be accepted only at a rising edge where start=1 and the state is IDLE or DONE.
REQ-015 On acceptance the block SHALL capture quo, opb and rem; later input changes SHALL not affect the result.
REQ-016 On acceptance the block SHALL load a 74-bit accumulator with zero-extended rem, a 74-bit multiplicand with zero-extended quo, a 24-bit multiplier with opb and an iteration counter with 0, and SHALL enter BUSY.
REQ-017 In each BUSY cycle the block SHALL:
  - add the multiplicand to the accumulator if multiplier bit 0 is 1;
  - shift the multiplicand left 1 bit;
  - shift the multiplier right 1 bit;
  - increment the counter.
REQ-018 After exactly 24 BUSY cycles (counter reaching 23 on its final iteration) the block SHALL go to DONE.
REQ-019 busy SHALL be 1 in every BUSY-state cycle and 0 otherwise.
REQ-020 Latency: busy SHALL be high for exactly 24 cycles starting the cycle after acceptance; done SHALL be high in the 25th cycle after acceptance, for exactly one cycle.
REQ-021 On entering DONE, prod SHALL be set to accumulator[49:0] and ovf to the OR of accumulator[73:50].
REQ-022 prod and ovf SHALL hold their values until the next operation's DONE entry.
REQ-023 A 74-bit accumulator SHALL be used; the maximum (2^50-1)*2^24 cannot overflow it.
REQ-024 From DONE with start=0 the block SHALL return to IDLE.
REQ-025 From DONE with start=1 the block SHALL accept the new operation and go to BUSY (back-to-back, no idle cycle).
REQ-026 start while BUSY SHALL be ignored, with no queuing and no effect on the current result.
REQ-027 opb=0 SHALL still take the full 24 cycles and yield prod=rem[49:0], ovf=0.
REQ-028 Throughput SHALL be one operation per 25 cycles.

Reset
REQ-029 When reset=1 at a rising edge, regardless of state:
  - state SHALL go to IDLE;
  - busy, done, ovf SHALL go to 0;
  - prod, accumulator, multiplicand, multiplier and counter SHALL go to 0.
REQ-030 reset SHALL take priority over start in the same cycle; the start SHALL be dropped.
REQ-031 Reset asserted during BUSY SHALL abort the operation, with no done pulse and prod=0.

Verification
REQ-032 quo=3, opb=5, rem=2, start pulsed -> busy high 24 cycles, then done=1 one cycle later with prod=17, ovf=0.
REQ-033 quo=0x3FFFFFFFFFFFF, opb=0xFFFFFF, rem=0x3FFFFFFFFFFFF -> prod=0x3FFFFFF000000, ovf=1.
REQ-034 quo=1234, opb=0, rem=99 -> after 25 cycles prod=99, ovf=0; quo=0, opb=0xFFFFFF, rem=0 -> prod=0.
REQ-035 start with quo=3, opb=5, rem=2; at cycle 10 pulse start with quo=7, opb=7, rem=0 -> second start ignored; single done with prod=17.
REQ-036 start asserted in the done cycle with quo=10, opb=10, rem=1 -> busy the next cycle; second done 25 cycles later with prod=101.
REQ-037 reset asserted at BUSY cycle 12 -> busy=0, done=0, prod=0 next cycle; no done pulse follows; a fresh start then completes normally.
